cal_meas: RTL and testbench

- Measurement front-end that produces the go / curr / per transaction consumed by the driver-board current normaliser (cal_norm).
- Measures the motor-drive pulse period in clk cycles and captures the most recent ADC current sample within that period.
- Issues a one-cycle go strobe with per and curr held stable for the normaliser's processing window.
- Sits between the drive pulse generator / current ADC interface and cal_norm.

---
 rtl/cal_pkg.sv | 21 ++
 rtl/cal_meas_edge_sync.sv | 28 ++
 rtl/cal_meas.sv | 153 +++++++++++++++
 tb/tb_cal_meas.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cal_pkg.sv
// Shared definitions for the calibration measurement path (cal_meas / cal_norm).
package cal_pkg;

  // Measurement FSM states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    MEAS = 2'd2,
    HOLD = 2'd3
  } cal_state_e;

  // Default width of the period counter, per and curr
  localparam int CNT_W_DEF = 16;

  // Default number of cycles per/curr stay frozen after go; cal_norm sizes its latency to this
  localparam int HOLD_CYC_DEF = 300;

  // Default smallest period, in clk cycles, treated as a real drive pulse
  localparam int MIN_PER_DEF = 4;

endpackage

// File: rtl/cal_meas_edge_sync.sv
// Two-flop synchroniser plus registered rising-edge detect for one asynchronous input.
module edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic async_i,
  output logic rise_o
);

  logic [1:0] sync_q;
  logic       prev_q;
  logic       rise_q;

  // Bring the input into the clk domain, remember its last level and register the rising edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= 2'b00;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], async_i};
      prev_q <= sync_q[1];
      rise_q <= sync_q[1] & ~prev_q;
    end
  end

  assign rise_o = rise_q;

endmodule

// File: rtl/cal_meas.sv
// Drive-pulse period measurement with current-sample capture, feeding cal_norm via go/per/curr.
module cal_meas
  import cal_pkg::*;
#(
  parameter int CNT_W    = CNT_W_DEF,
  parameter int HOLD_CYC = HOLD_CYC_DEF,
  parameter int MIN_PER  = MIN_PER_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             pulse_in,
  input  logic [CNT_W-1:0] adc_data,
  input  logic             adc_valid,
  output logic             go,
  output logic [CNT_W-1:0] per,
  output logic [CNT_W-1:0] curr,
  output logic             busy,
  output logic             ovf
);

  localparam int               HW        = $clog2(HOLD_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] MIN_PER_C = CNT_W'(MIN_PER);
  localparam logic [HW-1:0]    HOLD_LD   = HW'(HOLD_CYC);
  localparam logic [HW-1:0]    HOLD_ONE  = HW'(1);

  cal_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [HW-1:0]    hold_q, hold_d;
  logic [CNT_W-1:0] sample_q, sample_d;
  logic             svalid_q, svalid_d;
  logic [CNT_W-1:0] per_q, per_d;
  logic [CNT_W-1:0] curr_q, curr_d;
  logic             go_q, go_d;
  logic             ovf_q, ovf_d;
  logic             en_q;
  logic             edge_det;

  edge_sync u_pulse_sync (
    .clk     (clk),
    .rst     (rst),
    .async_i (pulse_in),
    .rise_o  (edge_det)
  );

  // State and datapath registers; en_q remembers the previous enable level for ovf clearing
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      hold_q   <= '0;
      sample_q <= '0;
      svalid_q <= 1'b0;
      per_q    <= '0;
      curr_q   <= '0;
      go_q     <= 1'b0;
      ovf_q    <= 1'b0;
      en_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hold_q   <= hold_d;
      sample_q <= sample_d;
      svalid_q <= svalid_d;
      per_q    <= per_d;
      curr_q   <= curr_d;
      go_q     <= go_d;
      ovf_q    <= ovf_d;
      en_q     <= en;
    end
  end

  // Next-state logic: measure edge-to-edge, publish a period only when a sample was seen in it
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hold_d   = hold_q;
    sample_d = sample_q;
    svalid_d = svalid_q;
    per_d    = per_q;
    curr_d   = curr_q;
    go_d     = 1'b0;
    ovf_d    = ovf_q;

    case (state_q)
      IDLE: begin
        cnt_d    = '0;
        hold_d   = '0;
        svalid_d = 1'b0;
        if (en) state_d = ARM;
      end
      ARM: begin
        if (edge_det) begin
          cnt_d    = CNT_ONE;
          svalid_d = 1'b0;
          state_d  = MEAS;
        end
      end
      MEAS: begin
        if (cnt_q == CNT_MAX) begin
          ovf_d    = 1'b1;
          cnt_d    = '0;
          svalid_d = 1'b0;
          state_d  = ARM;
        end else if (edge_det) begin
          if ((cnt_q >= MIN_PER_C) && (svalid_q || adc_valid)) begin
            per_d   = cnt_q;
            curr_d  = adc_valid ? adc_data : sample_q;
            go_d    = 1'b1;
            hold_d  = HOLD_LD;
            state_d = HOLD;
          end else begin
            cnt_d    = CNT_ONE;
            svalid_d = adc_valid;
            if (adc_valid) sample_d = adc_data;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
          if (adc_valid) begin
            sample_d = adc_data;
            svalid_d = 1'b1;
          end
        end
      end
      HOLD: begin
        if (hold_q <= HOLD_ONE) begin
          hold_d  = '0;
          state_d = ARM;
        end else begin
          hold_d = hold_q - HOLD_ONE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (!en) begin
      state_d = IDLE;
      go_d    = 1'b0;
      per_d   = per_q;
      curr_d  = curr_q;
      ovf_d   = en_q ? 1'b0 : ovf_q;
    end
  end

  assign go   = go_q;
  assign per  = per_q;
  assign curr = curr_q;
  assign busy = (state_q == HOLD);
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_cal_meas.sv
// Directed self-checking bench for cal_meas.
module tb_cal_meas;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic         pulse_in;
  logic [W-1:0] adc_data;
  logic         adc_valid;
  logic         go;
  logic [W-1:0] per;
  logic [W-1:0] curr;
  logic         busy;
  logic         ovf;

  int checks = 0;
  int errors = 0;

  int   cyc = 0;
  int   pulsePer = 0;
  int   phase = 0;
  logic pulseLevel = 1'b0;
  int   adcPhase = 0;
  logic adcStepOn = 1'b0;
  logic adcOnce = 1'b0;
  int   adcVal = 0;
  int   adcStep = 0;
  int   lastAdcSent = 0;
  int   lastRiseCyc = 0;
  int   goCount = 0;
  int   goCyc = 0;
  int   prevGoCyc = 0;
  int   goPer = 0;
  int   goCurr = 0;

  cal_meas dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .pulse_in  (pulse_in),
    .adc_data  (adc_data),
    .adc_valid (adc_valid),
    .go        (go),
    .per       (per),
    .curr      (curr),
    .busy      (busy),
    .ovf       (ovf)
  );

  // Free-running 10 ns clock
  always #5 clk = ~clk;

  // Advance n cycles: observe outputs just after the edge, then drive the pulse/ADC pattern
  task automatic applyStimulus(input int n);
    logic newPulse;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      cyc++;
      if (go === 1'b1) begin
        goCount++;
        prevGoCyc = goCyc;
        goCyc     = cyc;
        goPer     = per;
        goCurr    = curr;
      end
      if (pulsePer > 0) newPulse = (phase < ((pulsePer >= 2) ? pulsePer / 2 : 1));
      else              newPulse = pulseLevel;
      adc_valid = 1'b0;
      if (pulsePer > 0 && phase == adcPhase && (adcStepOn || adcOnce)) begin
        adc_valid   = 1'b1;
        adc_data    = W'(adcVal);
        lastAdcSent = adcVal;
        adcVal      = adcVal + adcStep;
        adcOnce     = 1'b0;
      end
      if (newPulse && !pulse_in) lastRiseCyc = cyc;
      pulse_in = newPulse;
      if (pulsePer > 0) phase = (phase + 1) % pulsePer;
    end
  endtask

  // Run until a new go pulse is seen or the budget expires
  task automatic waitGo(input int budget, output bit seen);
    int start;
    start = goCount;
    seen  = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      applyStimulus(1);
      if (goCount > start) seen = 1'b1;
    end
  endtask

  // Put the DUT and the stimulus generator back into a quiet reset state
  task automatic applyReset();
    rst        = 1'b1;
    en         = 1'b0;
    pulsePer   = 0;
    phase      = 0;
    pulseLevel = 1'b0;
    pulse_in   = 1'b0;
    adc_valid  = 1'b0;
    adc_data   = '0;
    adcOnce    = 1'b0;
    adcStepOn  = 1'b0;
    adcStep    = 0;
    applyStimulus(3);
    rst = 1'b0;
    applyStimulus(2);
  endtask

  task automatic test_reset();
    applyReset();
    checks++;
    if ({go, busy, ovf} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL reset_flags got go/busy/ovf=%b%b%b want 000", go, busy, ovf);
    end
    checks++;
    if (per !== 16'd0 || curr !== 16'd0) begin
      errors++;
      $display("[TB] FAIL reset_data got per=%0d curr=%0d want 0 0", per, curr);
    end
  endtask

  task automatic test_basic();
    bit seen;
    int busyCnt;
    applyReset();
    en = 1'b1;
    adcVal = 61000; adcStep = 0; adcPhase = 50; adcStepOn = 1'b1;
    pulsePer = 100; phase = 0;
    waitGo(400, seen);
    checks++;
    if (!seen) begin
      errors++;
      $display("[TB] FAIL basic_go got no go want go within 400 cycles");
    end
    checks++;
    if (goPer !== 100 || goCurr !== 61000) begin
      errors++;
      $display("[TB] FAIL basic_data got per=%0d curr=%0d want 100 61000", goPer, goCurr);
    end
    checks++;
    if (goCyc - lastRiseCyc !== 4) begin
      errors++;
      $display("[TB] FAIL basic_latency got %0d want 4 (cycles from drive to go)", goCyc - lastRiseCyc);
    end
    busyCnt = (busy === 1'b1) ? 1 : 0;
    while (busy === 1'b1 && busyCnt < 400) begin
      applyStimulus(1);
      if (busy === 1'b1) busyCnt++;
    end
    checks++;
    if (busyCnt !== 300) begin
      errors++;
      $display("[TB] FAIL basic_busy got %0d want 300 busy cycles", busyCnt);
    end
  endtask

  task automatic test_continuous();
    bit seen;
    int sep;
    applyReset();
    en = 1'b1;
    adcVal = 1000; adcStep = 1000; adcPhase = 30; adcStepOn = 1'b1;
    pulsePer = 150; phase = 0;
    waitGo(600, seen);
    checks++;
    if (!seen || goPer !== 150 || goCurr !== 1000) begin
      errors++;
      $display("[TB] FAIL cont_first got seen=%0d per=%0d curr=%0d want 1 150 1000", seen, goPer, goCurr);
    end
    waitGo(900, seen);
    checks++;
    if (!seen || goPer !== 150 || goCurr !== lastAdcSent) begin
      errors++;
      $display("[TB] FAIL cont_second got seen=%0d per=%0d curr=%0d want 1 150 %0d", seen, goPer, goCurr, lastAdcSent);
    end
    sep = goCyc - prevGoCyc;
    checks++;
    if (sep < 600 || sep >= 750) begin
      errors++;
      $display("[TB] FAIL cont_spacing got %0d want 600..749", sep);
    end
  endtask

  task automatic test_short_period();
    bit seen;
    int start;
    applyReset();
    en = 1'b1;
    adcVal = 500; adcStep = 0; adcPhase = 0; adcStepOn = 1'b1;
    pulsePer = 3; phase = 0;
    start = goCount;
    applyStimulus(300);
    checks++;
    if (goCount !== start || ovf !== 1'b0) begin
      errors++;
      $display("[TB] FAIL short_period got gos=%0d ovf=%b want 0 0", goCount - start, ovf);
    end
    applyReset();
    en = 1'b1;
    adcVal = 800; adcStep = 0; adcPhase = 1; adcStepOn = 1'b1;
    pulsePer = 4; phase = 0;
    waitGo(60, seen);
    checks++;
    if (!seen || goPer !== 4 || goCurr !== 800) begin
      errors++;
      $display("[TB] FAIL min_period got seen=%0d per=%0d curr=%0d want 1 4 800", seen, goPer, goCurr);
    end
  endtask

  task automatic test_overflow();
    bit seen;
    int start;
    applyReset();
    en = 1'b1;
    pulseLevel = 1'b1;
    applyStimulus(4);
    pulseLevel = 1'b0;
    start = goCount;
    applyStimulus(70000);
    checks++;
    if (ovf !== 1'b1 || goCount !== start) begin
      errors++;
      $display("[TB] FAIL ovf_set got ovf=%b gos=%0d want 1 0", ovf, goCount - start);
    end
    adcVal = 7777; adcStep = 0; adcPhase = 100; adcStepOn = 1'b1;
    pulsePer = 200; phase = 0;
    waitGo(700, seen);
    checks++;
    if (!seen || goPer !== 200 || ovf !== 1'b1) begin
      errors++;
      $display("[TB] FAIL ovf_recover got seen=%0d per=%0d ovf=%b want 1 200 1", seen, goPer, ovf);
    end
    en = 1'b0;
    applyStimulus(2);
    checks++;
    if (ovf !== 1'b0) begin
      errors++;
      $display("[TB] FAIL ovf_clear got %b want 0", ovf);
    end
  endtask

  task automatic test_no_sample();
    bit seen;
    int start;
    applyReset();
    en = 1'b1;
    pulsePer = 120; phase = 0;
    start = goCount;
    applyStimulus(500);
    checks++;
    if (goCount !== start) begin
      errors++;
      $display("[TB] FAIL no_sample got %0d gos want 0", goCount - start);
    end
    adcVal = 4242; adcStep = 0; adcPhase = 60; adcOnce = 1'b1;
    waitGo(300, seen);
    checks++;
    if (!seen || goPer !== 120 || goCurr !== 4242) begin
      errors++;
      $display("[TB] FAIL late_sample got seen=%0d per=%0d curr=%0d want 1 120 4242", seen, goPer, goCurr);
    end
  endtask

  task automatic test_en_drop();
    int start;
    applyReset();
    en = 1'b1;
    adcVal = 999; adcStep = 0; adcPhase = 20; adcStepOn = 1'b1;
    pulsePer = 200; phase = 0;
    start = goCount;
    applyStimulus(55);
    en = 1'b0;
    applyStimulus(600);
    checks++;
    if (goCount !== start || per !== 16'd0 || curr !== 16'd0 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL en_drop got gos=%0d per=%0d curr=%0d busy=%b want 0 0 0 0", goCount - start, per, curr, busy);
    end
  endtask

  task automatic test_reset_hold();
    bit seen;
    int start;
    applyReset();
    en = 1'b1;
    adcVal = 1234; adcStep = 0; adcPhase = 50; adcStepOn = 1'b1;
    pulsePer = 100; phase = 0;
    waitGo(400, seen);
    applyStimulus(20);
    checks++;
    if (busy !== 1'b1 || per !== 16'd100) begin
      errors++;
      $display("[TB] FAIL hold_before_rst got busy=%b per=%0d want 1 100", busy, per);
    end
    @(negedge clk);
    rst = 1'b1;
    en  = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || per !== 16'd0 || curr !== 16'd0 || go !== 1'b0) begin
      errors++;
      $display("[TB] FAIL async_rst got busy=%b per=%0d curr=%0d go=%b want 0 0 0 0", busy, per, curr, go);
    end
    start = goCount;
    applyStimulus(2);
    rst = 1'b0;
    applyStimulus(300);
    checks++;
    if (goCount !== start || per !== 16'd0 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL after_rst got gos=%0d per=%0d busy=%b want 0 0 0", goCount - start, per, busy);
    end
  endtask

  // Scenario sequence followed by the single summary line
  initial begin
    rst = 1'b1; en = 1'b0; pulse_in = 1'b0; adc_valid = 1'b0; adc_data = '0;
    test_reset();
    test_basic();
    test_continuous();
    test_short_period();
    test_overflow();
    test_no_sample();
    test_en_drop();
    test_reset_hold();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
